// File: rtl/alu_ctrl_pkg.sv
// ============================================================================
// Module   : alu_ctrl_pkg
// Brief    : Shared constants and types for the pipelined ALU control stage.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package alu_ctrl_pkg;

  // Main-decoder ALU classes
  localparam logic [1:0] c_aluop_ldst  = 2'b00;
  localparam logic [1:0] c_aluop_cbz   = 2'b01;
  localparam logic [1:0] c_aluop_rtype = 2'b10;
  localparam logic [1:0] c_aluop_itype = 2'b11;

  // ALU control encodings (4-bit core, zero-extended to CTRL_W)
  localparam logic [3:0] c_ctrl_and     = 4'b0000;
  localparam logic [3:0] c_ctrl_orr     = 4'b0001;
  localparam logic [3:0] c_ctrl_add     = 4'b0010;
  localparam logic [3:0] c_ctrl_eor     = 4'b0011;
  localparam logic [3:0] c_ctrl_lsl     = 4'b0100;
  localparam logic [3:0] c_ctrl_lsr     = 4'b0101;
  localparam logic [3:0] c_ctrl_sub     = 4'b0110;
  localparam logic [3:0] c_ctrl_passb   = 4'b0111;
  localparam logic [3:0] c_ctrl_mul     = 4'b1000;
  localparam logic [3:0] c_ctrl_div     = 4'b1001;
  localparam logic [3:0] c_ctrl_illegal = 4'b1111;

  // R-type opcodes, instruction bits [31:21]
  localparam logic [10:0] c_op_add  = 11'b10001011000;
  localparam logic [10:0] c_op_sub  = 11'b11001011000;
  localparam logic [10:0] c_op_and  = 11'b10001010000;
  localparam logic [10:0] c_op_orr  = 11'b10101010000;
  localparam logic [10:0] c_op_eor  = 11'b11001010000;
  localparam logic [10:0] c_op_lsl  = 11'b11010011011;
  localparam logic [10:0] c_op_lsr  = 11'b11010011010;
  localparam logic [10:0] c_op_mul  = 11'b10011011000;
  localparam logic [10:0] c_op_udiv = 11'b10011010110;

  // I-type opcodes, instruction bits [31:22]
  localparam logic [9:0] c_op_addi = 10'b1001000100;
  localparam logic [9:0] c_op_subi = 10'b1101000100;
  localparam logic [9:0] c_op_andi = 10'b1001001000;
  localparam logic [9:0] c_op_orri = 10'b1011001000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_BUSY  = 2'd1,
    ST_VALID = 2'd2
  } state_t;

endpackage

`default_nettype wire

// File: rtl/alu_control_pipe_decode.sv
// ============================================================================
// Module   : alu_ctrl_decode
// Brief    : Combinational ALUop/opcode decode. UDIV support is enabled by
//            defining ALU_CTRL_DIV_EN; otherwise UDIV decodes as illegal.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_ctrl_decode
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W = 4
) (
  input  logic [1:0]        i_alu_op,
  input  logic [10:0]       i_opcode,
  output logic [CTRL_W-1:0] o_ctrl,
  output logic              o_is_multi,
  output logic              o_illegal
);

  logic [3:0] w_code;
  logic       w_hit;
  logic       w_multi;

  always_comb begin
    w_code  = c_ctrl_illegal;
    w_hit   = 1'b0;
    w_multi = 1'b0;
    case (i_alu_op)
      c_aluop_ldst: begin w_code = c_ctrl_add;   w_hit = 1'b1; end
      c_aluop_cbz:  begin w_code = c_ctrl_passb; w_hit = 1'b1; end
      c_aluop_rtype: begin
        case (i_opcode)
          c_op_add: begin w_code = c_ctrl_add; w_hit = 1'b1; end
          c_op_sub: begin w_code = c_ctrl_sub; w_hit = 1'b1; end
          c_op_and: begin w_code = c_ctrl_and; w_hit = 1'b1; end
          c_op_orr: begin w_code = c_ctrl_orr; w_hit = 1'b1; end
          c_op_eor: begin w_code = c_ctrl_eor; w_hit = 1'b1; end
          c_op_lsl: begin w_code = c_ctrl_lsl; w_hit = 1'b1; end
          c_op_lsr: begin w_code = c_ctrl_lsr; w_hit = 1'b1; end
          c_op_mul: begin w_code = c_ctrl_mul; w_hit = 1'b1; w_multi = 1'b1; end
`ifdef ALU_CTRL_DIV_EN
          c_op_udiv: begin w_code = c_ctrl_div; w_hit = 1'b1; w_multi = 1'b1; end
`endif
          default: ;
        endcase
      end
      c_aluop_itype: begin
        // Bit 21 is part of the immediate field for I-type, so it is ignored
        case (i_opcode[10:1])
          c_op_addi: begin w_code = c_ctrl_add; w_hit = 1'b1; end
          c_op_subi: begin w_code = c_ctrl_sub; w_hit = 1'b1; end
          c_op_andi: begin w_code = c_ctrl_and; w_hit = 1'b1; end
          c_op_orri: begin w_code = c_ctrl_orr; w_hit = 1'b1; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign o_ctrl     = CTRL_W'(w_code);
  assign o_is_multi = w_multi;
  assign o_illegal  = ~w_hit;

endmodule

`default_nettype wire

// File: rtl/alu_control_pipe.sv
// ============================================================================
// Module   : alu_control_pipe
// Brief    : Registered, handshaked LEGv8 ALU control stage with multi-cycle
//            MUL/UDIV latency tracking. Macro: ALU_CTRL_DIV_EN enables UDIV.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module alu_control_pipe
  import alu_ctrl_pkg::*;
#(
  parameter int CTRL_W  = 4,
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 8
) (
  input  logic              CLK,
  input  logic              Reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [1:0]        ALUop,
  input  logic [10:0]       Opcode,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] ALUCtrl,
  output logic              Busy,
  output logic              Illegal
);

`ifdef ALU_CTRL_DIV_EN
  localparam int c_cnt_w = $clog2(((MUL_LAT > DIV_LAT) ? MUL_LAT : DIV_LAT) + 1);
`else
  // DIV_LAT has no effect on sizing here; the zero term only references it
  localparam int c_cnt_w = $clog2(MUL_LAT + 1) + 0 * DIV_LAT;
`endif

  state_t              r_state;
  logic [c_cnt_w-1:0]  r_cnt;
  logic [CTRL_W-1:0]   r_ctrl;
  logic                r_illegal;
  logic                r_out_valid;
  logic                r_busy;

  logic [CTRL_W-1:0]   w_dec_ctrl;
  logic                w_dec_multi;
  logic                w_dec_illegal;
  logic                w_accept;
  logic [c_cnt_w-1:0]  w_lat_load;

  alu_ctrl_decode #(.CTRL_W(CTRL_W)) u_decode (
    .i_alu_op   (ALUop),
    .i_opcode   (Opcode),
    .o_ctrl     (w_dec_ctrl),
    .o_is_multi (w_dec_multi),
    .o_illegal  (w_dec_illegal)
  );

  assign in_ready = (r_state == ST_IDLE) | ((r_state == ST_VALID) & out_ready);
  assign w_accept = in_valid & in_ready;

  // Count loads LAT-2: BUSY lasts LAT-1 cycles, VALID follows on the last one
`ifdef ALU_CTRL_DIV_EN
  assign w_lat_load = (w_dec_ctrl == CTRL_W'(c_ctrl_div)) ? c_cnt_w'(DIV_LAT - 2)
                                                           : c_cnt_w'(MUL_LAT - 2);
`else
  assign w_lat_load = c_cnt_w'(MUL_LAT - 2);
`endif

  always_ff @(posedge CLK) begin
    if (Reset) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_ctrl      <= '0;
      r_illegal   <= 1'b0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else if (flush) begin
      r_state     <= ST_IDLE;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_VALID: begin
          if (w_accept) begin
            r_ctrl    <= w_dec_ctrl;
            r_illegal <= w_dec_illegal;
            if (w_dec_multi) begin
              r_state     <= ST_BUSY;
              r_cnt       <= w_lat_load;
              r_busy      <= 1'b1;
              r_out_valid <= 1'b0;
            end else begin
              r_state     <= ST_VALID;
              r_out_valid <= 1'b1;
            end
          end else if ((r_state == ST_VALID) && out_ready) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
          end
        end
        ST_BUSY: begin
          if (r_cnt == '0) begin
            r_state     <= ST_VALID;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 1'b1;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_cnt       <= '0;
          r_busy      <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  assign out_valid = r_out_valid;
  assign Busy      = r_busy;
  assign ALUCtrl   = r_ctrl;
  assign Illegal   = r_illegal;

endmodule

`default_nettype wire
